// File: rtl/digit_entry.sv
// rtl/digit_entry.sv - debounced three-digit entry with submit/lock/clear for the answer-check stage.
// Optional macro SUBMIT_TIMEOUT_EN: auto-clear after LOCK_CYCLES cycles in LOCKED.
module digit_entry #(
  parameter int DB_CYCLES   = 16,
  parameter int MAX_DIGIT   = 9,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  input  logic       BTN_ENTER,
  input  logic       BTN_CLR,
  output logic [3:0] DISP1,
  output logic [3:0] DISP2,
  output logic [3:0] DISP3,
  output logic [3:0] COUNT1_OUT,
  output logic [3:0] COUNT2_OUT,
  output logic [3:0] COUNT3_OUT,
  output logic       LOCKED,
  output logic       SUBMIT_PULSE
);

  localparam int              CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   DB_LIM  = CW'(DB_CYCLES);
  localparam logic [3:0]      DIG_MAX = 4'(MAX_DIGIT);

  typedef enum logic {ST_ENTRY, ST_LOCKED} state_t;

  // Button index map: 0..2 digits, 3 enter, 4 clear.
  logic [4:0]    raw_d;
  logic [4:0]    sync1_q, sync2_q, db_q, db_prev_q, press_q;
  logic [CW-1:0] cnt_q [5];

  assign raw_d = {BTN_CLR, BTN_ENTER, BTN3, BTN2, BTN1};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw_d;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LIM) begin
          db_q[i]  <= ~db_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_t     state_q;
  logic [3:0] disp_q  [3];
  logic [3:0] count_q [3];
  logic       locked_q, submit_q;
  logic       timeout_hit_d, clr_ev_d, enter_ev_d, any_nz_d;
  logic [2:0] dig_ev_d;

`ifdef SUBMIT_TIMEOUT_EN
  localparam int            TW      = $clog2(LOCK_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(LOCK_CYCLES - 1);
  logic [TW-1:0] tmo_q;

  // Counter is held at zero outside LOCKED, so it starts fresh on every entry.
  always_ff @(posedge CLK) begin
    if (!RST || state_q != ST_LOCKED) tmo_q <= '0;
    else                              tmo_q <= tmo_q + 1'b1;
  end

  assign timeout_hit_d = (state_q == ST_LOCKED) && (tmo_q == TMO_LIM);
`else
  assign timeout_hit_d = 1'b0;
`endif

  assign dig_ev_d   = press_q[2:0];
  assign enter_ev_d = press_q[3];
  assign clr_ev_d   = press_q[4] | timeout_hit_d;
  assign any_nz_d   = (disp_q[0] != 4'd0) || (disp_q[1] != 4'd0) || (disp_q[2] != 4'd0);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_ENTRY;
      locked_q <= 1'b0;
      submit_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        disp_q[i]  <= 4'd0;
        count_q[i] <= 4'd0;
      end
    end else begin
      submit_q <= 1'b0;
      if (clr_ev_d) begin
        state_q  <= ST_ENTRY;
        locked_q <= 1'b0;
        for (int i = 0; i < 3; i++) begin
          disp_q[i]  <= 4'd0;
          count_q[i] <= 4'd0;
        end
      end else if (state_q == ST_ENTRY) begin
        // A submit freezes the pre-increment digits and drops same-cycle digit presses.
        if (enter_ev_d && any_nz_d) begin
          for (int i = 0; i < 3; i++) count_q[i] <= disp_q[i];
          submit_q <= 1'b1;
          locked_q <= 1'b1;
          state_q  <= ST_LOCKED;
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (dig_ev_d[i]) disp_q[i] <= (disp_q[i] == DIG_MAX) ? 4'd0 : disp_q[i] + 4'd1;
          end
        end
      end
    end
  end

  assign DISP1        = disp_q[0];
  assign DISP2        = disp_q[1];
  assign DISP3        = disp_q[2];
  assign COUNT1_OUT   = count_q[0];
  assign COUNT2_OUT   = count_q[1];
  assign COUNT3_OUT   = count_q[2];
  assign LOCKED       = locked_q;
  assign SUBMIT_PULSE = submit_q;

endmodule

// File: tb/tb_digit_entry.sv
// tb/tb_digit_entry.sv - directed self-checking bench for digit_entry (DB_CYCLES=4).
module tb_digit_entry;

`ifdef SUBMIT_TIMEOUT_EN
  localparam int LOCK = 8;
`else
  localparam int LOCK = 1024;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn = 5'b0;
  logic [3:0] disp1, disp2, disp3, cnt1, cnt2, cnt3;
  logic       locked, submit;
  int         tests = 0;
  int         failed = 0;
  int         pulse_cnt = 0;

  always #5 clk = ~clk;

  digit_entry #(.DB_CYCLES(4), .MAX_DIGIT(9), .LOCK_CYCLES(LOCK)) dut (
    .CLK(clk), .RST(rst),
    .BTN1(btn[0]), .BTN2(btn[1]), .BTN3(btn[2]), .BTN_ENTER(btn[3]), .BTN_CLR(btn[4]),
    .DISP1(disp1), .DISP2(disp2), .DISP3(disp3),
    .COUNT1_OUT(cnt1), .COUNT2_OUT(cnt2), .COUNT3_OUT(cnt3),
    .LOCKED(locked), .SUBMIT_PULSE(submit)
  );

  always @(negedge clk) if (submit) pulse_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] mask);
    btn = mask;
    step(10);
    btn = 5'b0;
    step(12);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_disp"}, {disp1, disp2, disp3}, 0);
    check({tag, "_count"}, {cnt1, cnt2, cnt3}, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_pulse"}, submit, 0);
  endtask

  initial begin
    int p0;
    int n;
    // Reset with buttons toggling.
    rst = 1'b0;
    btn = 5'b10101;
    step(1);
    btn = 5'b01010;
    step(1);
    check_zero("reset");
    btn = 5'b0;
    rst = 1'b1;
    step(15);
    check_zero("post_reset");

    // Debounce: short glitch, then a clean press, then a long hold.
    btn = 5'b00001;
    step(3);
    btn = 5'b0;
    step(15);
    check("glitch_disp1", disp1, 0);
    press(5'b00001);
    check("press_disp1", disp1, 1);
    btn = 5'b00010;
    step(40);
    btn = 5'b0;
    step(12);
    check("hold_disp2", disp2, 1);

    // Wrap on digit 3.
    for (int i = 0; i < 10; i++) begin
      press(5'b00100);
      check($sformatf("wrap_disp3_%0d", i), disp3, (i + 1) % 10);
    end
    for (int i = 0; i < 9; i++) press(5'b00100);
    check("wrap_disp3_final", disp3, 9);

    // Build 3,5,9.
    for (int i = 0; i < 2; i++) press(5'b00001);
    for (int i = 0; i < 4; i++) press(5'b00010);
    check("pre_submit", {disp1, disp2, disp3}, {4'd3, 4'd5, 4'd9});

`ifndef SUBMIT_TIMEOUT_EN
    p0 = pulse_cnt;
    press(5'b01000);
    check("submit_count", {cnt1, cnt2, cnt3}, {4'd3, 4'd5, 4'd9});
    check("submit_pulse_cycles", pulse_cnt - p0, 1);
    check("submit_locked", locked, 1);
    press(5'b00010);
    press(5'b00010);
    press(5'b01000);
    check("locked_disp2", disp2, 5);
    check("locked_count2", cnt2, 5);
    check("locked_no_pulse", pulse_cnt - p0, 1);
    press(5'b10000);
    check_zero("clr_locked");
`else
    press(5'b10000);
    check_zero("clr_entry");
`endif

    // ENTER with all zero is ignored.
    p0 = pulse_cnt;
    press(5'b01000);
    check("zero_enter_pulse", pulse_cnt - p0, 0);
    check("zero_enter_locked", locked, 0);

    // CLR and ENTER in the same cycle: clear only.
    press(5'b00001);
    check("pre_clr_enter_disp1", disp1, 1);
    p0 = pulse_cnt;
    press(5'b11000);
    check_zero("clr_enter");
    check("clr_enter_pulse", pulse_cnt - p0, 0);

    // Raw-to-display latency: DB_CYCLES+4 cycles after the first raw-high sample.
    btn = 5'b00001;
    n = 0;
    while (disp1 == 4'd0 && n < 30) begin
      step(1);
      n++;
    end
    check("latency_in_window", (n - 1 >= 7 && n - 1 <= 9) ? 1 : 0, 1);
    btn = 5'b0;
    step(12);
    check("latency_disp1", disp1, 1);

    // Submit 1,0,0 and observe how long LOCKED lasts.
    btn = 5'b01000;
    n = 0;
    while (!submit && n < 30) begin
      step(1);
      n++;
    end
    check("submit100_seen", submit, 1);
    n = 0;
    while (locked && n < 40) begin
      step(1);
      n++;
    end
`ifdef SUBMIT_TIMEOUT_EN
    check("timeout_cycles", n, 8);
    check("timeout_count1", cnt1, 0);
    check("timeout_disp1", disp1, 0);
`else
    check("no_timeout_locked", locked, 1);
    check("no_timeout_count1", cnt1, 1);
`endif
    btn = 5'b0;
    step(12);
    press(5'b10000);
    check_zero("after_timeout_test");

    // Reset during a lock and mid-debounce.
    press(5'b00010);
    press(5'b01000);
    btn = 5'b00100;
    step(3);
    rst = 1'b0;
    step(1);
    check_zero("reset_locked");
    rst = 1'b1;
    btn = 5'b0;
    step(15);
    check("reset_mid_db_disp3", disp3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
